// File: rtl/aes_dec_key_sched.sv
// aes_dec_key_sched: sequential AES-128 key expansion with a registered row-major round-key read port

// aes_sbox32: four parallel AES S-boxes computed as GF(2^8) inverse plus affine map
module aes_sbox32 (
  input  logic [31:0] a,
  output logic [31:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] p, input logic [7:0] q);
    logic [7:0] acc, x;
    acc = '0;
    x = p;
    for (int i = 0; i < 8; i++) begin
      if (q[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
  function automatic logic [7:0] sbox8(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, v;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    v    = gmul(gmul(x240, x12), x2);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign y[8*i +: 8] = sbox8(a[8*i +: 8]);
  end
endmodule

module aes_dec_key_sched #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic         rk_rd_en,
  input  logic [3:0]   rk_rd_addr,
  output logic [127:0] rk_rd_data,
  output logic         rk_rd_valid
);
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
  state_t state, state_nx;
  logic [3:0] rcnt, rnext;
  logic [127:0] store [0:NR];
  logic [31:0] w0, w1, w2, w3, sub, t, n0, n1, n2, n3;
  logic [7:0] rcon;
  logic accept, last;

  // stored words are FIPS columns; readers expect the row-major state layout
  function automatic logic [127:0] to_rows(input logic [127:0] k);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        to_rows[127-8*(4*r+c) -: 8] = k[127-8*(4*c+r) -: 8];
  endfunction

  assign key_ready = state != EXPAND;
  assign busy = state == EXPAND;
  assign accept = key_valid && key_ready;
  assign last = rcnt == 4'(NR - 1);
  assign rnext = rcnt + 4'd1;
  assign {w0, w1, w2, w3} = store[rcnt];
  assign rcon = rcnt < 4'd8 ? 8'h01 << rcnt : rcnt == 4'd8 ? 8'h1b : 8'h36;
  assign t = sub ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = n0 ^ w1;
  assign n2 = n1 ^ w2;
  assign n3 = n2 ^ w3;

  aes_sbox32 u_sbox (.a({w3[23:0], w3[31:24]}), .y(sub));

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  // a new key always restarts expansion; the last round lands in READY
  always_comb state_nx = accept ? EXPAND : (state == EXPAND && last) ? READY : state;

  // key store, round counter and completion flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) store[i] <= '0;
      rcnt <= '0;
      done <= 1'b0;
      keys_valid <= 1'b0;
    end else begin
      done <= state == EXPAND && last;
      if (accept) begin
        store[0] <= key_in;
        rcnt <= '0;
        keys_valid <= 1'b0;
      end else if (state == EXPAND) begin
        store[rnext] <= {n0, n1, n2, n3};
        rcnt <= last ? '0 : rnext;
        if (last) keys_valid <= 1'b1;
      end
    end

  // registered read port, served only from a complete schedule
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rk_rd_data <= '0;
      rk_rd_valid <= 1'b0;
    end else begin
      rk_rd_valid <= rk_rd_en && state == READY;
      if (rk_rd_en && state == READY)
        rk_rd_data <= rk_rd_addr <= 4'(NR) ? to_rows(store[rk_rd_addr]) : '0;
    end
endmodule

// File: tb/tb_aes_dec_key_sched.sv
// tb_aes_dec_key_sched: directed scoreboard bench for the AES-128 key schedule
module tb_aes_dec_key_sched;
  logic clk = 1'b0, rst_n = 1'b0, key_valid = 1'b0, rk_rd_en = 1'b0;
  logic [127:0] key_in = '0;
  logic [3:0] rk_rd_addr = '0;
  logic key_ready, busy, done, keys_valid, rk_rd_valid;
  logic [127:0] rk_rd_data;
  int n_cmp = 0, n_bad = 0;
  logic [127:0] exp_q[$];

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R0  = 128'h2b28ab097eaef7cf15d2154f16a6883c;
  localparam logic [127:0] K1_R1  = 128'ha088232afa54a36cfe2c397617b13905;
  localparam logic [127:0] K1_R10 = 128'hd0c9e1b614ee3f63f9250c0ca889c8a6;
  localparam logic [127:0] Z_R1   = 128'h62626262636363636363636363636363;
  localparam logic [127:0] Z_R10  = 128'hb43e236fef92e98f5be25118cb11cf8e;

  aes_dec_key_sched dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_in(key_in),
    .key_ready(key_ready), .busy(busy), .done(done), .keys_valid(keys_valid),
    .rk_rd_en(rk_rd_en), .rk_rd_addr(rk_rd_addr), .rk_rd_data(rk_rd_data),
    .rk_rd_valid(rk_rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_flags(input string name, input logic b, input logic d, input logic kv);
    chk({name, " busy"}, 128'(busy), 128'(b));
    chk({name, " key_ready"}, 128'(key_ready), 128'(!b));
    chk({name, " done"}, 128'(done), 128'(d));
    chk({name, " keys_valid"}, 128'(keys_valid), 128'(kv));
  endtask

  task automatic chk_reset(input string name);
    chk_flags(name, 1'b0, 1'b0, 1'b0);
    chk({name, " rd_valid"}, 128'(rk_rd_valid), 128'd0);
    chk({name, " rd_data"}, rk_rd_data, 128'd0);
  endtask

  // issue a read on the next edge; its expected data joins the scoreboard
  task automatic rd(input logic [3:0] a, input logic [127:0] e);
    rk_rd_en = 1'b1;
    rk_rd_addr = a;
    exp_q.push_back(e);
    @(negedge clk);
    rk_rd_en = 1'b0;
  endtask

  // present a key for one edge, then check the ten expansion cycles and the done cycle
  task automatic load(input logic [127:0] k, input string name);
    key_valid = 1'b1;
    key_in = k;
    @(negedge clk);
    key_valid = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      chk_flags($sformatf("%s cyc%0d", name, i), i <= 10, i == 11, i == 11);
      @(negedge clk);
    end
    chk_flags({name, " after"}, 1'b0, 1'b0, 1'b1);
  endtask

  // monitor: every valid read must match the oldest outstanding expectation
  always @(negedge clk)
    if (rk_rd_valid) begin
      if (exp_q.size() == 0) chk("unexpected rd_valid", rk_rd_data, 128'hx);
      else chk("rd_data", rk_rd_data, exp_q.pop_front());
    end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    rk_rd_en = 1'b1;
    @(negedge clk);
    rk_rd_en = 1'b0;
    chk_reset("idle read refused");
    key_valid = 1'b1;
    key_in = K1;
    @(negedge clk);
    key_valid = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      chk_flags($sformatf("k1 cyc%0d", i), i <= 10, i == 11, i == 11);
      chk("k1 expand rd_valid", 128'(rk_rd_valid), 128'd0);
      rk_rd_en = i inside {[2:3]};
      key_valid = i inside {[4:5]};
      key_in = '0;
      @(negedge clk);
    end
    rk_rd_en = 1'b0;
    chk_flags("k1 after", 1'b0, 1'b0, 1'b1);
    chk("k1 held data", rk_rd_data, 128'd0);
    rd(4'd10, K1_R10);
    rd(4'd1, K1_R1);
    rd(4'd0, K1_R0);
    @(negedge clk);
    chk("rd_valid drops", 128'(rk_rd_valid), 128'd0);
    key_valid = 1'b1;
    key_in = '0;
    rk_rd_en = 1'b1;
    rk_rd_addr = 4'd10;
    exp_q.push_back(K1_R10);
    @(negedge clk);
    key_valid = 1'b0;
    rk_rd_en = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      chk_flags($sformatf("zero cyc%0d", i), i <= 10, i == 11, i == 11);
      if (i >= 2) chk("zero expand held data", rk_rd_data, K1_R10);
      rk_rd_en = i == 3;
      @(negedge clk);
    end
    rk_rd_en = 1'b0;
    rd(4'd1, Z_R1);
    rd(4'd10, Z_R10);
    rd(4'd15, 128'd0);
    @(negedge clk);
    key_valid = 1'b1;
    key_in = K1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk_flags("pre-reset", 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset("mid-expand reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("post reset idle");
    load(K1, "reload");
    rd(4'd1, K1_R1);
    rd(4'd0, K1_R0);
    repeat (2) @(negedge clk);
    chk("scoreboard drained", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
